// File: rtl/slot_mailbox_reader.sv
// Reader side of a slot-indexed mailbox: slot storage, 1-cycle indexed reads, per-slot
// written/unread tracking and a status-scan FSM. Define MBOX_CLR_ON_READ_EN so that reads also clear written[].
module slot_mailbox_reader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [IW-1:0]    rd_idx,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_undriven,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_done,
    output logic [CW-1:0]    undriven_cnt,
    output logic [CW-1:0]    unread_cnt,
    output logic [7:0]       ovw_cnt,
    input  logic             ovw_clr
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [DEPTH-1:0] unread_q, unread_d;
    logic [7:0]       ovw_q, ovw_d;

    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_undriven_q;

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic [CW-1:0]    acc_undrv_q, acc_unread_q;
    logic [CW-1:0]    undrv_inc, unread_inc;
    logic [CW-1:0]    undriven_cnt_q, unread_cnt_q;
    logic             scan_busy_q, scan_done_q;

    // Write is applied after the read clear so that a same-slot write wins.
    always_comb begin
        written_d = written_q;
        unread_d  = unread_q;
        if (rd_req) begin
            unread_d[rd_idx] = 1'b0;
`ifdef MBOX_CLR_ON_READ_EN
            written_d[rd_idx] = 1'b0;
`endif
        end
        if (wr_en) begin
            written_d[wr_idx] = 1'b1;
            unread_d[wr_idx]  = 1'b1;
        end

        ovw_d = ovw_q;
        if (ovw_clr) begin
            ovw_d = 8'd0;
        end else if (wr_en && unread_q[wr_idx] && (ovw_q != 8'hFF)) begin
            ovw_d = ovw_q + 8'd1;
        end

        undrv_inc  = {{(CW-1){1'b0}}, ~written_q[ptr_q]};
        unread_inc = {{(CW-1){1'b0}}, unread_q[ptr_q]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q     <= '0;
            unread_q      <= '0;
            ovw_q         <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_undriven_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= wr_data;
            end
            written_q  <= written_d;
            unread_q   <= unread_d;
            ovw_q      <= ovw_d;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q     <= mem_q[rd_idx];
                rd_undriven_q <= ~written_q[rd_idx];
            end
        end
    end

    // Counts are loaded on the edge entering DONE so they are valid alongside scan_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            acc_undrv_q    <= '0;
            acc_unread_q   <= '0;
            undriven_cnt_q <= '0;
            unread_cnt_q   <= '0;
            scan_busy_q    <= 1'b0;
            scan_done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (scan_start) begin
                        state_q      <= S_SCAN;
                        ptr_q        <= '0;
                        acc_undrv_q  <= '0;
                        acc_unread_q <= '0;
                        scan_busy_q  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    acc_undrv_q  <= acc_undrv_q + undrv_inc;
                    acc_unread_q <= acc_unread_q + unread_inc;
                    if (ptr_q == IW'(DEPTH - 1)) begin
                        state_q        <= S_DONE;
                        undriven_cnt_q <= acc_undrv_q + undrv_inc;
                        unread_cnt_q   <= acc_unread_q + unread_inc;
                        scan_done_q    <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    scan_done_q <= 1'b0;
                    scan_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    scan_done_q <= 1'b0;
                    scan_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_undriven  = rd_undriven_q;
    assign scan_busy    = scan_busy_q;
    assign scan_done    = scan_done_q;
    assign undriven_cnt = undriven_cnt_q;
    assign unread_cnt   = unread_cnt_q;
    assign ovw_cnt      = ovw_q;

endmodule

// File: tb/tb_slot_mailbox_reader.sv
// Directed bench for slot_mailbox_reader (DEPTH=8, WIDTH=32); expectations follow MBOX_CLR_ON_READ_EN when defined.
module tb_slot_mailbox_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_idx;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_undriven;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [3:0]  undriven_cnt;
    logic [3:0]  unread_cnt;
    logic [7:0]  ovw_cnt;
    logic        ovw_clr;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef MBOX_CLR_ON_READ_EN
    localparam bit CLR_RD = 1'b1;
`else
    localparam bit CLR_RD = 1'b0;
`endif

    slot_mailbox_reader #(.DEPTH(8), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_undriven(rd_undriven),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .undriven_cnt(undriven_cnt), .unread_cnt(unread_cnt),
        .ovw_cnt(ovw_cnt), .ovw_clr(ovw_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  k;
        bit  saw_done;

        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        rd_req = 1'b0; rd_idx = '0; scan_start = 1'b0; ovw_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_undriven", rd_undriven, 0);
        check("rst_scan_busy", scan_busy, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_undriven_cnt", undriven_cnt, 0);
        check("rst_unread_cnt", unread_cnt, 0);
        check("rst_ovw_cnt", ovw_cnt, 0);

        // Test 1: read of a never-written slot
        rd_req = 1'b1; rd_idx = 3'd3;
        tick();
        rd_req = 1'b0;
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_data", rd_data, 0);
        check("t1_rd_undriven", rd_undriven, 1);
        tick();
        check("t1_rd_valid_drop", rd_valid, 0);
        check("t1_rd_undriven_hold", rd_undriven, 1);

        // Test 2: write/read idx 2, then a full scan
        wr_en = 1'b1; wr_idx = 3'd2; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rd_req = 1'b1; rd_idx = 3'd2;
        tick();
        rd_req = 1'b0;
        check("t2_rd_valid", rd_valid, 1);
        check("t2_rd_data", rd_data, 32'hDEADBEEF);
        check("t2_rd_undriven", rd_undriven, 0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        k = 1;
        check("t2_scan_busy", scan_busy, 1);
        while (!scan_done && k < 30) begin
            tick();
            k++;
        end
        check("t2_scan_latency", k, 9);
        check("t2_undriven_cnt", undriven_cnt, CLR_RD ? 8 : 7);
        check("t2_unread_cnt", unread_cnt, 0);
        check("t2_busy_in_done", scan_busy, 1);
        tick();
        check("t2_done_pulse", scan_done, 0);
        check("t2_busy_clear", scan_busy, 0);
        check("t2_cnt_hold", unread_cnt, 0);

        // Test 3: overwrite counting, saturation and clear priority
        wr_en = 1'b1; wr_idx = 3'd5; wr_data = 32'h1;
        tick();
        wr_data = 32'h2;
        tick();
        wr_en = 1'b0;
        check("t3_ovw_one", ovw_cnt, 1);
        wr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = 32'h100 + i;
            tick();
        end
        wr_en = 1'b0;
        check("t3_ovw_sat", ovw_cnt, 255);
        wr_en = 1'b1; ovw_clr = 1'b1; wr_data = 32'h55;
        tick();
        wr_en = 1'b0; ovw_clr = 1'b0;
        check("t3_ovw_clr_wins", ovw_cnt, 0);

        // Test 4: same-cycle read and write of slot 1
        wr_en = 1'b1; wr_idx = 3'd1; wr_data = 32'h22;
        tick();
        wr_en = 1'b0; rd_req = 1'b1; rd_idx = 3'd1;
        tick();
        check("t4_pre_rd_data", rd_data, 32'h22);
        wr_en = 1'b1; wr_idx = 3'd1; wr_data = 32'h11;
        tick();
        wr_en = 1'b0;
        check("t4_same_rd_data", rd_data, 32'h22);
        check("t4_same_rd_undriven", rd_undriven, CLR_RD ? 1 : 0);
        check("t4_same_no_ovw", ovw_cnt, 0);
        tick();
        rd_req = 1'b0;
        check("t4_next_rd_data", rd_data, 32'h11);
        check("t4_next_rd_undriven", rd_undriven, 0);
        check("t4_next_no_ovw", ovw_cnt, 0);

        // Test 5: reset aborts a scan, then a full scan with an ignored restart
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_abort_busy", scan_busy, 0);
        check("t5_abort_undriven_cnt", undriven_cnt, 0);
        saw_done = scan_done;
        for (int i = 0; i < 12; i++) begin
            tick();
            saw_done = saw_done | scan_done;
        end
        check("t5_abort_no_done", saw_done, 0);
        check("t5_abort_ovw", ovw_cnt, 0);
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_idx = 3'(i); wr_data = 32'hA0 + i;
            tick();
        end
        wr_en = 1'b0;
        check("t5_no_ovw", ovw_cnt, 0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        k = 1;
        while (!scan_done && k < 30) begin
            scan_start = (k == 3);
            tick();
            k++;
        end
        scan_start = 1'b0;
        check("t5_scan_latency", k, 9);
        check("t5_undriven_cnt", undriven_cnt, 0);
        check("t5_unread_cnt", unread_cnt, 8);
        tick(); tick();
        check("t5_restart_ignored", scan_busy, 0);

        // Test 6: consecutive reads of a written slot
        wr_en = 1'b1; wr_idx = 3'd0; wr_data = 32'h77;
        tick();
        wr_en = 1'b0; rd_req = 1'b1; rd_idx = 3'd0;
        tick();
        check("t6_first_undriven", rd_undriven, 0);
        check("t6_first_data", rd_data, 32'h77);
        tick();
        rd_req = 1'b0;
        check("t6_second_undriven", rd_undriven, CLR_RD ? 1 : 0);
        check("t6_second_data", rd_data, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/slot_mailbox_reader.md
Name: slot_mailbox_reader

Overview:
Reader end of a slot-indexed mailbox. An upstream writer posts words into numbered slots with write-only strobes. This block holds the slot storage and serves indexed reads with 1-cycle latency. It tracks per-slot driven/unread status, so software and dataflow checks can detect slots that were never written or were overwritten before being read. A scan FSM reports aggregate undriven/unread counts on request.

Parameters:
DEPTH, 8, number of slots; power of two, 2..256
WIDTH, 32, data width per slot
IW, $clog2(DEPTH), slot index width (derived, localparam)
CW, $clog2(DEPTH+1), count width (derived, localparam)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  writer strobe
wr_idx  in  IW  slot written
wr_data  in  WIDTH  data written
rd_req  in  1  read request
rd_idx  in  IW  slot read
rd_valid  out  1  read response valid (1-cycle pulse)
rd_data  out  WIDTH  read response data
rd_undriven  out  1  response slot had never been written
scan_start  in  1  start status scan
scan_busy  out  1  scan FSM not IDLE
scan_done  out  1  1-cycle pulse, counts valid
undriven_cnt  out  CW  slots with written=0 at scan
unread_cnt  out  CW  slots with unread=1 at scan
ovw_cnt  out  8  saturating count of overwrite-before-read events
ovw_clr  in  1  clears ovw_cnt

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All written[] and unread[] bits cleared; storage cleared to 0.
  - rd_valid=0, rd_data=0, rd_undriven=0.
  - scan_busy=0, scan_done=0, undriven_cnt=0, unread_cnt=0, ovw_cnt=0.
  - FSM goes to IDLE.
  - Reset mid-scan aborts the scan; no scan_done is emitted.
- Write (wr_en=1):
  - mem[wr_idx]<=wr_data, written[wr_idx]<=1, unread[wr_idx]<=1.
  - If unread[wr_idx] was already 1, ovw_cnt increments, saturating at 255.
- ovw_clr and an overwrite in the same cycle: clear wins, result 0.
- Read (rd_req=1), issued in cycle N. Next cycle (N+1):
  - rd_valid=1 and rd_data=mem[rd_idx] as of cycle N.
  - rd_undriven=~written[rd_idx] as of cycle N.
  - unread[rd_idx] cleared.
  - No rd_req: rd_valid=0, and rd_data/rd_undriven hold their last values.
  - Reads are always accepted; there is no backpressure.
- Same-slot read and write in the same cycle:
  - The read returns the old data and the old written bit.
  - After the edge, unread=1 and written=1 (write wins).
  - No overwrite is counted unless unread was already 1 before the cycle.
- Scan FSM: states IDLE, SCAN, DONE.
  - IDLE: scan_start=1 -> SCAN; ptr<=0, accumulators<=0.
  - SCAN: each cycle visits slot ptr and adds ~written[ptr] and unread[ptr] to the accumulators. ptr==DEPTH-1 -> DONE; otherwise ptr++.
  - DONE: undriven_cnt/unread_cnt load the accumulators; scan_done=1 for this one cycle; -> IDLE.
  - scan_busy=1 in SCAN and DONE. scan_start is ignored unless in IDLE.
  - Latency from scan_start to scan_done is DEPTH+1 cycles.
  - Each slot is sampled on the cycle it is visited. Writes and reads continue normally during a scan.
  - Counts hold until the next DONE. Their max value is DEPTH, hence the CW width.

Optional Feature:
MBOX_CLR_ON_READ_EN
- Defined: a read also clears written[rd_idx], so the slot reports rd_undriven=1 until it is written again. Data is still returned unmasked.
- A same-cycle write to the same slot sets written=1 (write wins).
- Not defined: written[] bits are sticky until reset.

Test Plan:
1. Reset, then rd_req idx 3 -> next cycle rd_valid=1, rd_data=0, rd_undriven=1.
2. Write idx 2 =0xDEADBEEF, then read idx 2 -> rd_data=0xDEADBEEF, rd_undriven=0; scan -> unread_cnt=0, undriven_cnt=7, scan_done exactly 9 cycles after scan_start.
3. Write idx 5 twice without a read -> ovw_cnt=1. 300 further unread writes -> ovw_cnt=255. ovw_clr with a simultaneous overwrite -> 0.
4. Same-cycle write 0x11 and read on idx 1 (previously 0x22) -> rd_data=0x22. A following read returns 0x11 and counts no overwrite.
5. scan_start, reset after 3 cycles -> scan_busy=0 and no scan_done. Then write all 8 slots and scan -> undriven_cnt=0, unread_cnt=8; a second scan_start during the scan is ignored.
6. With MBOX_CLR_ON_READ_EN: write idx 0, read twice -> rd_undriven=0 then 1. Without the macro -> 0 then 0.
